// File: rtl/iob_cache_pkg.sv
// Shared definitions for the iob_cache back-end arbiter.
// Holds the arbiter FSM state encoding used by iob_cache_be_arb.
package iob_cache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;  // no owner, arbitrating
    localparam state_t GNT  = 2'd1;  // owner's request driven to memory
    localparam state_t RD   = 2'd2;  // read accepted, waiting for rvalid

endpackage

// File: rtl/iob_cache_rr_prio.sv
// Round-robin priority encoder.
// Picks the first asserted request strictly after index 'last',
// wrapping from N-1 back to 0. Output is one-hot, all-zero if no request.
module iob_cache_rr_prio #(
    parameter int N      = 2,
    parameter int LAST_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      req,
    input  logic [LAST_W-1:0] last,
    output logic [N-1:0]      gnt
);

    logic found;
    int   idx;

    // Scan N positions starting just after the last-served requester
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_cache_be_arb.sv
// Round-robin arbiter sharing one IOb Native memory port among N cache
// back-ends. One transaction outstanding at a time.
// Optional feature: define IOB_CACHE_BE_ARB_LOCK_EN to add m_lock_i, which
// keeps the grant across back-to-back transactions (atomic line fills and
// write-backs).
module iob_cache_be_arb
    import iob_cache_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      cke_i,
    input  logic [N-1:0]              m_avalid_i,
    input  logic [N*ADDR_W-1:0]       m_addr_i,
    input  logic [N*DATA_W-1:0]       m_wdata_i,
    input  logic [N*(DATA_W/8)-1:0]   m_wstrb_i,
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    input  logic [N-1:0]              m_lock_i,
`endif
    output logic [N-1:0]              m_ready_o,
    output logic [N-1:0]              m_rvalid_o,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic                      s_avalid_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    output logic [(DATA_W/8)-1:0]     s_wstrb_o,
    input  logic                      s_ready_i,
    input  logic                      s_rvalid_i,
    input  logic [DATA_W-1:0]         s_rdata_i,
    output logic [N-1:0]              grant_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LAST_W = (N > 1) ? $clog2(N) : 1;

    state_t              state_q, state_d;
    logic [N-1:0]        grant_q, grant_d;
    logic [LAST_W-1:0]   last_q, last_d;
    logic [N-1:0]        rr_gnt;
    logic [N-1:0]        lock_w;
    logic [LAST_W-1:0]   g_idx;
    logic                sel_avalid;
    logic [NBYTES-1:0]   sel_wstrb;
    logic                sel_write;
    logic                done;

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
    assign lock_w = m_lock_i;
`else
    assign lock_w = '0;
`endif

    iob_cache_rr_prio #(
        .N      (N),
        .LAST_W (LAST_W)
    ) u_rr_prio (
        .req  (m_avalid_i),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // Binary index of the one-hot grant (0 when idle; unused then)
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) g_idx = LAST_W'(i);
        end
    end

    assign sel_avalid = m_avalid_i[g_idx];
    assign sel_wstrb  = m_wstrb_i[int'(g_idx)*NBYTES +: NBYTES];
    assign sel_write  = |sel_wstrb;

    // State, grant and last-served registers; cke_i low freezes them
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_W'(N - 1);
        end else if (cke_i) begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitration, handshake tracking and grant release/lock
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_avalid_i) begin
                    state_d = GNT;
                    grant_d = rr_gnt;
                end
            end
            GNT: begin
                if (!sel_avalid) begin
                    // Owner withdrew: release without touching memory
                    state_d = IDLE;
                    grant_d = '0;
                end else if (s_ready_i) begin
                    last_d = g_idx;
                    // Writes finish at the handshake; a read finishes here
                    // too when the memory answers in the same cycle
                    if (sel_write || s_rvalid_i) done = 1'b1;
                    else                         state_d = RD;
                end
            end
            RD: begin
                if (s_rvalid_i) done = 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (done) begin
            if (lock_w[g_idx]) begin
                state_d = GNT;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end
    end

    // Outputs: route the owner's request to memory and responses back
    always_comb begin
        s_avalid_o = 1'b0;
        s_addr_o   = m_addr_i[int'(g_idx)*ADDR_W +: ADDR_W];
        s_wdata_o  = m_wdata_i[int'(g_idx)*DATA_W +: DATA_W];
        s_wstrb_o  = sel_wstrb;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        m_rdata_o  = s_rdata_i;
        case (state_q)
            GNT: begin
                s_avalid_o       = sel_avalid;
                m_ready_o[g_idx] = s_ready_i;
                if (sel_avalid && s_ready_i && !sel_write)
                    m_rvalid_o[g_idx] = s_rvalid_i;
            end
            RD: begin
                m_rvalid_o[g_idx] = s_rvalid_i;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_iob_cache_be_arb.sv
// Self-checking bench for iob_cache_be_arb (N=2): directed scenarios plus a
// randomized phase, all checked every cycle against an ownership model.
module tb_iob_cache_be_arb;

    localparam int N      = 2;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int NB     = DATA_W / 8;

    logic                clk = 1'b0;
    logic                arst_n;
    logic                cke;
    logic [N-1:0]        m_avalid;
    logic [N*ADDR_W-1:0] m_addr;
    logic [N*DATA_W-1:0] m_wdata;
    logic [N*NB-1:0]     m_wstrb;
    logic [N-1:0]        lock_v;
    logic [N-1:0]        m_ready, m_rvalid, grant;
    logic [DATA_W-1:0]   m_rdata;
    logic                s_avalid;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic [NB-1:0]       s_wstrb;
    logic                s_ready, s_rvalid;
    logic [DATA_W-1:0]   s_rdata;

    iob_cache_be_arb #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .cke_i      (cke),
        .m_avalid_i (m_avalid),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_wstrb_i  (m_wstrb),
`ifdef IOB_CACHE_BE_ARB_LOCK_EN
        .m_lock_i   (lock_v),
`endif
        .m_ready_o  (m_ready),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .s_avalid_o (s_avalid),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_wstrb_o  (s_wstrb),
        .s_ready_i  (s_ready),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .grant_o    (grant)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Model: who owns the port, whether a read is outstanding, last served
    int           owner;
    bit           in_read;
    int           last;
    logic [N-1:0] ev_acc, ev_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NB-1:0] strb_of(input int k);
        return m_wstrb[k*NB +: NB];
    endfunction

    task automatic set_req(input int k, input bit v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [NB-1:0] s);
        m_avalid[k]                = v;
        m_addr[k*ADDR_W +: ADDR_W] = a;
        m_wdata[k*DATA_W +: DATA_W] = d;
        m_wstrb[k*NB +: NB]        = s;
    endtask

    task automatic model_reset();
        owner   = -1;
        in_read = 1'b0;
        last    = N - 1;
        ev_acc  = '0;
        ev_rv   = '0;
    endtask

    task automatic check_model();
        logic [N-1:0] eg, emr, erv;
        logic         esav;
        eg = '0; emr = '0; erv = '0; esav = 1'b0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            if (!in_read) begin
                esav       = m_avalid[owner];
                emr[owner] = s_ready;
                if (esav && s_ready && strb_of(owner) == '0) erv[owner] = s_rvalid;
            end else begin
                erv[owner] = s_rvalid;
            end
        end
        chk($sformatf("cyc%0d grant", cyc), 64'(grant), 64'(eg));
        chk($sformatf("cyc%0d s_avalid", cyc), 64'(s_avalid), 64'(esav));
        chk($sformatf("cyc%0d m_ready", cyc), 64'(m_ready), 64'(emr));
        chk($sformatf("cyc%0d m_rvalid", cyc), 64'(m_rvalid), 64'(erv));
        if (esav) begin
            chk($sformatf("cyc%0d s_addr", cyc), 64'(s_addr), 64'(m_addr[owner*ADDR_W +: ADDR_W]));
            chk($sformatf("cyc%0d s_wdata", cyc), 64'(s_wdata), 64'(m_wdata[owner*DATA_W +: DATA_W]));
            chk($sformatf("cyc%0d s_wstrb", cyc), 64'(s_wstrb), 64'(strb_of(owner)));
        end
        if (|erv) chk($sformatf("cyc%0d m_rdata", cyc), 64'(m_rdata), 64'(s_rdata));
    endtask

    task automatic finish_txn();
        in_read = 1'b0;
        if (!lock_v[owner]) owner = -1;
    endtask

    task automatic model_update();
        ev_acc = '0;
        ev_rv  = '0;
        if (!cke) return;
        if (owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (last + i) % N;
                if (owner < 0 && m_avalid[k]) owner = k;
            end
        end else if (!in_read) begin
            if (!m_avalid[owner]) begin
                owner = -1;
            end else if (s_ready) begin
                ev_acc[owner] = 1'b1;
                last          = owner;
                if (strb_of(owner) != '0) finish_txn();
                else if (s_rvalid) begin ev_rv[owner] = 1'b1; finish_txn(); end
                else in_read = 1'b1;
            end
        end else if (s_rvalid) begin
            ev_rv[owner] = 1'b1;
            finish_txn();
        end
    endtask

    // One clock: check outputs against the model, advance it, cross the edge
    task automatic tick();
        #1;
        check_model();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        arst_n   = 1'b0;
        m_avalid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        lock_v   = '0;
        s_ready  = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        cke      = 1'b1;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          hs_cnt, c0, c1, alt_err, prev, who, early;
        logic [N-1:0] valid_q, waiting;
        int          wait_tx [N];

        // Reset state with busy-looking inputs
        arst_n = 1'b0; cke = 1'b1; lock_v = '0;
        m_avalid = '1; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEAD;
        #3;
        chk("reset grant", 64'(grant), 0);
        chk("reset s_avalid", 64'(s_avalid), 0);
        chk("reset m_ready", 64'(m_ready), 0);
        chk("reset m_rvalid", 64'(m_rvalid), 0);
        do_reset();

        // Single read, 1-cycle memory latency
        set_req(0, 1, 24'h10, '0, '0);
        s_ready = 1'b1;
        #1; chk("rd t s_avalid", 64'(s_avalid), 0);
        tick();
        chk("rd t+1 s_avalid", 64'(s_avalid), 1);
        chk("rd t+1 s_addr", 64'(s_addr), 64'h10);
        chk("rd t+1 grant", 64'(grant), 64'b01);
        tick();
        set_req(0, 0, '0, '0, '0);
        s_ready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE;
        #1;
        chk("rd m_rvalid", 64'(m_rvalid), 64'b01);
        chk("rd m_rdata", 64'(m_rdata), 64'hCAFE);
        tick();
        s_rvalid = 1'b0;
        chk("rd grant released", 64'(grant), 0);

        // Zero-latency read from requester 1
        set_req(1, 1, 24'h20, '0, '0);
        tick();
        s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234;
        #1;
        chk("zl m_rvalid", 64'(m_rvalid), 64'b10);
        chk("zl m_rdata", 64'(m_rdata), 64'h1234);
        tick();
        set_req(1, 0, '0, '0, '0);
        s_rvalid = 1'b0;
        chk("zl grant released", 64'(grant), 0);
        tick();

        // Contention from reset: 0 first, then 1
        do_reset();
        set_req(0, 1, 24'h100, 32'hA0, 4'hF);
        set_req(1, 1, 24'h200, 32'hB0, 4'h3);
        s_ready = 1'b1;
        tick();
        chk("cont first grant", 64'(grant), 64'b01);
        tick();
        set_req(0, 0, '0, '0, '0);
        tick();
        chk("cont second grant", 64'(grant), 64'b10);
        tick();
        set_req(1, 0, '0, '0, '0);
        tick();

        // Fairness: both requesters write continuously
        do_reset();
        set_req(0, 1, 24'h300, 32'h11, 4'hF);
        set_req(1, 1, 24'h400, 32'h22, 4'hF);
        s_ready = 1'b1;
        hs_cnt = 0; c0 = 0; c1 = 0; alt_err = 0; prev = -1;
        for (int c = 0; c < 200 && hs_cnt < 20; c++) begin
            tick();
            if (s_avalid && s_ready) begin
                who = grant[1] ? 1 : 0;
                if (who == prev) alt_err++;
                if (who == 0) c0++; else c1++;
                prev = who;
                hs_cnt++;
            end
        end
        chk("fair total", 64'(hs_cnt), 20);
        chk("fair req0", 64'(c0), 10);
        chk("fair req1", 64'(c1), 10);
        chk("fair alternation errors", 64'(alt_err), 0);

        // Backpressure: memory not ready for 5 cycles
        do_reset();
        set_req(0, 1, 24'h55, 32'h5555, 4'hF);
        set_req(1, 1, 24'h66, 32'h6666, 4'hF);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d grant", i), 64'(grant), 64'b01);
            chk($sformatf("bp%0d m_ready", i), 64'(m_ready), 0);
            chk($sformatf("bp%0d s_addr", i), 64'(s_addr), 64'h55);
            tick();
        end
        s_ready = 1'b1;
        tick();
        set_req(0, 0, '0, '0, '0);
        chk("bp release", 64'(grant), 0);
        tick();
        chk("bp next grant", 64'(grant), 64'b10);
        tick();
        set_req(1, 0, '0, '0, '0);
        tick();

        // Reset pulsed while waiting for read data
        do_reset();
        set_req(0, 1, 24'h20, '0, '0);
        s_ready = 1'b1;
        tick();
        tick();
        set_req(0, 0, '0, '0, '0);
        s_ready = 1'b0;
        tick();
        arst_n = 1'b0;
        #1;
        chk("mid-rd rst grant", 64'(grant), 0);
        chk("mid-rd rst s_avalid", 64'(s_avalid), 0);
        chk("mid-rd rst m_ready", 64'(m_ready), 0);
        arst_n = 1'b1;
        model_reset();
        s_rvalid = 1'b1; s_rdata = 32'hBEEF;
        #1;
        chk("late rvalid dropped", 64'(m_rvalid), 0);
        tick();
        s_rvalid = 1'b0;
        set_req(1, 1, 24'h30, 32'h3, 4'h1);
        s_ready = 1'b1;
        tick();
        chk("post-rst grant", 64'(grant), 64'b10);
        chk("post-rst s_addr", 64'(s_addr), 64'h30);
        tick();
        set_req(1, 0, '0, '0, '0);
        tick();

        // Randomized traffic with starvation-bound tracking
        do_reset();
        valid_q = '0; waiting = '0;
        for (int k = 0; k < N; k++) wait_tx[k] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (ev_acc[k]) begin
                    valid_q[k] = 1'b0;
                    if (strb_of(k) == '0) waiting[k] = 1'b1;
                    m_avalid[k] = 1'b0;
                end
                if (ev_rv[k]) waiting[k] = 1'b0;
                if (valid_q[k] && $urandom_range(15) == 0) begin
                    valid_q[k] = 1'b0; m_avalid[k] = 1'b0; wait_tx[k] = 0;
                end else if (!valid_q[k] && !waiting[k] && $urandom_range(1) == 1) begin
                    logic [NB-1:0] s;
                    s = ($urandom_range(1) == 1) ? NB'($urandom_range(15, 1)) : '0;
                    set_req(k, 1, ADDR_W'($urandom), $urandom, s);
                    valid_q[k] = 1'b1;
                end
            end
            cke      = ($urandom_range(7) != 0);
            s_ready  = ($urandom_range(2) != 0);
            s_rvalid = in_read ? ($urandom_range(1) == 1) : ($urandom_range(3) == 0);
            s_rdata  = $urandom;
            tick();
            for (int k = 0; k < N; k++) begin
                if (ev_acc[k]) begin
                    chk($sformatf("starve req%0d within N", k), 64'(wait_tx[k] <= N), 1);
                    wait_tx[k] = 0;
                end else if (valid_q[k] && |ev_acc) begin
                    wait_tx[k]++;
                end
            end
        end

`ifdef IOB_CACHE_BE_ARB_LOCK_EN
        // Locked 4-beat read on requester 0 while requester 1 waits
        do_reset();
        set_req(1, 1, 24'h77, 32'h7, 4'hF);
        lock_v[0] = 1'b1;
        set_req(0, 1, 24'h40, '0, '0);
        s_ready = 1'b1;
        tick();
        early = 0;
        for (int b = 0; b < 4; b++) begin
            lock_v[0] = (b < 3);
            set_req(0, 1, ADDR_W'(24'h40 + b), '0, '0);
            if (grant !== 2'b01) early++;
            tick();
            set_req(0, 0, '0, '0, '0);
            s_rvalid = 1'b1; s_rdata = DATA_W'(b);
            if (grant !== 2'b01) early++;
            tick();
            s_rvalid = 1'b0;
        end
        chk("lock early grants", 64'(early), 0);
        chk("lock released", 64'(grant), 0);
        tick();
        chk("lock req1 granted", 64'(grant), 64'b10);
        tick();
        set_req(1, 0, '0, '0, '0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
